// File: rtl/plot_arbiter.sv
// plot_arbiter: merges NUM_CH plot channels onto one VGA plot port and scores cursor overlaps.
// Optional minimum-dwell qualification of overlap exits is enabled by PLOT_ARBITER_MIN_DWELL_EN.
module plot_arbiter #(
  parameter int NUM_CH        = 4,
  parameter int X_W           = 8,
  parameter int Y_W           = 7,
  parameter int COLOUR_W      = 3,
  parameter int PRIORITY_MODE = 0,
  parameter int HIT_THRESHOLD = 500,
  parameter int SCORE_DIGITS  = 2,
  parameter int MIN_DWELL     = 16
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic                       score_clr,
  input  logic [NUM_CH*X_W-1:0]      ch_x,
  input  logic [NUM_CH*Y_W-1:0]      ch_y,
  input  logic [NUM_CH*COLOUR_W-1:0] ch_colour,
  output logic [X_W-1:0]             x_plot,
  output logic [Y_W-1:0]             y_plot,
  output logic [COLOUR_W-1:0]        colour,
  output logic                       overlap,
  output logic [4*SCORE_DIGITS-1:0]  score_bcd,
  output logic                       score_wrap
);

  if (NUM_CH < 2 || NUM_CH > 8 ||
      HIT_THRESHOLD < 1 || HIT_THRESHOLD > 1023 ||
      SCORE_DIGITS < 1 || SCORE_DIGITS > 4 ||
      MIN_DWELL < 1) begin : g_bad_param
    $error("plot_arbiter: illegal parameter");
  end

  typedef enum logic {S_IDLE, S_IN} state_t;

  logic [3:0]          nz_cnt;
  logic [2:0]          first;
  logic                found;
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [COLOUR_W-1:0] sel_c;
  logic                sel_ov;

  // Count drawing channels and find the lowest-index one.
  always_comb begin
    nz_cnt = '0;
    first  = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_colour[i*COLOUR_W +: COLOUR_W] != '0) begin
        nz_cnt = nz_cnt + 4'd1;
        if (!found) begin
          found = 1'b1;
          first = 3'(i);
        end
      end
    end
  end

  // Pick the plotted pixel; collisions draw black at the cursor unless priority mode.
  always_comb begin
    sel_x = ch_x[X_W-1:0];
    sel_y = ch_y[Y_W-1:0];
    sel_c = '0;
    if (nz_cnt == 4'd1 ||
        (nz_cnt > 4'd1 && PRIORITY_MODE == 1)) begin
      sel_x = ch_x[first*X_W +: X_W];
      sel_y = ch_y[first*Y_W +: Y_W];
      sel_c = ch_colour[first*COLOUR_W +: COLOUR_W];
    end
    sel_ov = (ch_colour[COLOUR_W-1:0] != '0) &&
             (nz_cnt > 4'd1);
  end

  // Plot port register: one cycle latency, never stalls.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      x_plot  <= '0;
      y_plot  <= '0;
      colour  <= '0;
      overlap <= 1'b0;
    end else begin
      x_plot  <= sel_x;
      y_plot  <= sel_y;
      colour  <= sel_c;
      overlap <= sel_ov;
    end
  end

  logic [4*SCORE_DIGITS-1:0] score_inc;
  logic                      inc_carry;

  // BCD +1 with ripple carry; carry out of the top digit means wrap.
  always_comb begin
    score_inc = score_bcd;
    inc_carry = 1'b1;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (inc_carry) begin
        if (score_bcd[d*4 +: 4] == 4'd9) begin
          score_inc[d*4 +: 4] = 4'd0;
        end else begin
          score_inc[d*4 +: 4] = score_bcd[d*4 +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  state_t     state;
  logic [9:0] prescaler;
  logic       exit_ok;
  logic       hit;

  assign hit = (prescaler == 10'(HIT_THRESHOLD - 1));

`ifdef PLOT_ARBITER_MIN_DWELL_EN
  localparam int DW = $clog2(MIN_DWELL + 1);
  logic [DW-1:0] dwell;
  assign exit_ok = (dwell >= DW'(MIN_DWELL));
`else
  assign exit_ok = 1'b1;
`endif

  // Overlap scorer: counts exits from overlap, prescaled into a BCD score.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn || score_clr) begin
      state      <= S_IDLE;
      prescaler  <= '0;
      score_bcd  <= '0;
      score_wrap <= 1'b0;
`ifdef PLOT_ARBITER_MIN_DWELL_EN
      dwell      <= '0;
`endif
    end else begin
      score_wrap <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (overlap) begin
            state <= S_IN;
`ifdef PLOT_ARBITER_MIN_DWELL_EN
            dwell <= DW'(1);
`endif
          end
        end
        S_IN: begin
          if (!overlap) begin
            state <= S_IDLE;
`ifdef PLOT_ARBITER_MIN_DWELL_EN
            dwell <= '0;
`endif
            if (exit_ok) begin
              if (hit) begin
                prescaler  <= '0;
                score_bcd  <= score_inc;
                score_wrap <= inc_carry;
              end else begin
                prescaler <= prescaler + 10'd1;
              end
            end
          end
`ifdef PLOT_ARBITER_MIN_DWELL_EN
          else if (dwell < DW'(MIN_DWELL)) begin
            dwell <= dwell + DW'(1);
          end
`endif
        end
      endcase
    end
  end

endmodule
